// File: rtl/tod_pkg.sv
// Shared types and calendar helpers for the time-of-day keeper.
// Time is kept in plain binary fields; no BCD anywhere.
package tod_pkg;

    typedef enum logic [1:0] {
        ST_UNSET    = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_HOLDOVER = 2'd2
    } tod_state_e;

    typedef struct packed {
        logic [15:0] year;
        logic [7:0]  month;
        logic [7:0]  day;
        logic [7:0]  hour;
        logic [7:0]  min;
        logic [7:0]  sec;
    } tod_time_t;

    localparam logic [7:0] SEC_LAST      = 8'd59;
    localparam logic [7:0] MIN_LAST      = 8'd59;
    localparam logic [7:0] HOUR_LAST     = 8'd23;
    localparam logic [7:0] MONTH_LAST    = 8'd12;
    localparam logic [7:0] FIRST_DAY     = 8'd1;
    localparam logic [7:0] FIRST_MONTH   = 8'd1;
    localparam logic [7:0] DAYS_LONG     = 8'd31;
    localparam logic [7:0] DAYS_SHORT    = 8'd30;
    localparam logic [7:0] DAYS_FEB      = 8'd28;
    localparam logic [7:0] DAYS_FEB_LEAP = 8'd29;

    // Gregorian rule trimmed to the centuries this product will ever see.
    function automatic logic is_leap(input logic [15:0] year);
        logic leap;
        leap = (year[1:0] == 2'b00) && (year != 16'd2100) &&
               (year != 16'd2200) && (year != 16'd2300);
        return leap;
    endfunction

    function automatic logic [7:0] days_in_month(input logic [15:0] year,
                                                 input logic [7:0]  month);
        logic [7:0] days;
        case (month)
            8'd4, 8'd6, 8'd9, 8'd11: days = DAYS_SHORT;
            8'd2:                    days = is_leap(year) ? DAYS_FEB_LEAP : DAYS_FEB;
            default:                 days = DAYS_LONG;
        endcase
        return days;
    endfunction

endpackage

// File: rtl/tod_date_inc.sv
// Combinational +1 second on a time record, including all calendar rollovers.
// Wrap tests use >= so out-of-range loaded fields (leap second, bad day) still roll.
module tod_date_inc
    import tod_pkg::*;
(
    input  tod_time_t i_time,
    output tod_time_t o_time
);

    logic sec_wrap;
    logic min_wrap;
    logic hour_wrap;
    logic day_wrap;
    logic month_wrap;
    logic [7:0] dim;

    assign dim        = days_in_month(i_time.year, i_time.month);
    assign sec_wrap   = i_time.sec   >= SEC_LAST;
    assign min_wrap   = i_time.min   >= MIN_LAST;
    assign hour_wrap  = i_time.hour  >= HOUR_LAST;
    assign day_wrap   = i_time.day   >= dim;
    assign month_wrap = i_time.month >= MONTH_LAST;

    always_comb begin
        o_time     = i_time;
        o_time.sec = sec_wrap ? 8'd0 : i_time.sec + 8'd1;
        if (sec_wrap) begin
            o_time.min = min_wrap ? 8'd0 : i_time.min + 8'd1;
            if (min_wrap) begin
                o_time.hour = hour_wrap ? 8'd0 : i_time.hour + 8'd1;
                if (hour_wrap) begin
                    o_time.day = day_wrap ? FIRST_DAY : i_time.day + 8'd1;
                    if (day_wrap) begin
                        o_time.month = month_wrap ? FIRST_MONTH : i_time.month + 8'd1;
                        if (month_wrap) begin
                            o_time.year = i_time.year + 16'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tod_keeper.sv
// UTC time-of-day keeper: loads from decoded TSIP time packets, steps on 1PPS,
// and flywheels on an internal second counter when PPS disappears.
module tod_keeper
    import tod_pkg::*;
#(
    parameter int CLKS_PER_SEC = 10_000_000,
    parameter int PPS_WINDOW   = 1000,
    parameter int HOLDOVER_MAX = 10
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pps,
    input  logic        i_load_dv,
    input  logic [7:0]  i_year_h,
    input  logic [7:0]  i_year_l,
    input  logic [7:0]  i_month,
    input  logic [7:0]  i_day,
    input  logic [7:0]  i_hour,
    input  logic [7:0]  i_minutes,
    input  logic [7:0]  i_seconds,
    output logic [15:0] o_year,
    output logic [7:0]  o_month,
    output logic [7:0]  o_day,
    output logic [7:0]  o_hour,
    output logic [7:0]  o_minutes,
    output logic [7:0]  o_seconds,
    output logic        o_tick,
    output logic        o_valid,
    output logic        o_holdover
);

    localparam int CNT_W  = $clog2(CLKS_PER_SEC + PPS_WINDOW + 1);
    localparam int HCNT_W = $clog2(HOLDOVER_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_LOCK_LIM = CNT_W'(CLKS_PER_SEC + PPS_WINDOW - 1);
    localparam logic [CNT_W-1:0]  CNT_SEC_LIM  = CNT_W'(CLKS_PER_SEC - 1);
    localparam logic [CNT_W-1:0]  CNT_WIN      = CNT_W'(PPS_WINDOW);
    localparam logic [CNT_W-1:0]  CNT_MAX      = '1;
    localparam logic [HCNT_W-1:0] HCNT_MAX     = HCNT_W'(HOLDOVER_MAX);

    logic pps_meta_q, pps_meta_d;
    logic pps_sync_q, pps_sync_d;
    logic pps_prev_q, pps_prev_d;
    logic pps_rise_q, pps_rise_d;

    tod_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HCNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [HCNT_W-1:0] hold_inc;
    tod_time_t         time_q, time_d;
    logic              tick_q, tick_d;
    logic              valid_q, valid_d;
    logic              holdover_q, holdover_d;

    logic      tick_int;
    logic      syn_tick;
    tod_time_t load_time;
    tod_time_t inc_in;
    tod_time_t inc_out;

    assign load_time = {i_year_h, i_year_l, i_month, i_day, i_hour, i_minutes, i_seconds};

    // One incrementer serves both paths: a load in the tick cycle is stepped too.
    assign inc_in = i_load_dv ? load_time : time_q;

    tod_date_inc u_inc (
        .i_time (inc_in),
        .o_time (inc_out)
    );

    always_comb begin
        pps_meta_d = i_pps;
        pps_sync_d = pps_meta_q;
        pps_prev_d = pps_sync_q;
        pps_rise_d = pps_sync_q & ~pps_prev_q;

        state_d    = state_q;
        cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        hold_cnt_d = hold_cnt_q;
        hold_inc   = (hold_cnt_q == HCNT_MAX) ? hold_cnt_q : hold_cnt_q + HCNT_W'(1);
        valid_d    = valid_q;
        holdover_d = holdover_q;
        tick_int   = 1'b0;
        syn_tick   = 1'b0;

        case (state_q)
            ST_UNSET: begin
                if (pps_rise_q) cnt_d = '0;
                if (i_load_dv)  state_d = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (pps_rise_q) begin
                    tick_int = 1'b1;
                    cnt_d    = '0;
                end else if (cnt_q >= CNT_LOCK_LIM) begin
                    // PPS is already a window late: keep phase as if it had come on time.
                    tick_int   = 1'b1;
                    syn_tick   = 1'b1;
                    cnt_d      = CNT_WIN;
                    holdover_d = 1'b1;
                    state_d    = ST_HOLDOVER;
                end
            end
            ST_HOLDOVER: begin
                if (pps_rise_q) begin
                    // A PPS right behind our synthetic tick is the same second, late.
                    tick_int   = (cnt_q >= CNT_WIN);
                    cnt_d      = '0;
                    holdover_d = 1'b0;
                    hold_cnt_d = '0;
                    state_d    = ST_LOCKED;
                end else if (cnt_q >= CNT_SEC_LIM) begin
                    tick_int = 1'b1;
                    syn_tick = 1'b1;
                    cnt_d    = '0;
                end
            end
            default: state_d = ST_UNSET;
        endcase

        if (syn_tick) begin
            hold_cnt_d = hold_inc;
            if (hold_inc >= HCNT_MAX) valid_d = 1'b0;
        end

        if (i_load_dv) begin
            valid_d    = 1'b1;
            hold_cnt_d = '0;
        end

        time_d = tick_int ? inc_out : inc_in;
        tick_d = tick_int;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pps_meta_q <= 1'b0;
            pps_sync_q <= 1'b0;
            pps_prev_q <= 1'b0;
            pps_rise_q <= 1'b0;
            state_q    <= ST_UNSET;
            cnt_q      <= '0;
            hold_cnt_q <= '0;
            time_q     <= '0;
            tick_q     <= 1'b0;
            valid_q    <= 1'b0;
            holdover_q <= 1'b0;
        end else begin
            pps_meta_q <= pps_meta_d;
            pps_sync_q <= pps_sync_d;
            pps_prev_q <= pps_prev_d;
            pps_rise_q <= pps_rise_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_cnt_q <= hold_cnt_d;
            time_q     <= time_d;
            tick_q     <= tick_d;
            valid_q    <= valid_d;
            holdover_q <= holdover_d;
        end
    end

    assign o_year     = time_q.year;
    assign o_month    = time_q.month;
    assign o_day      = time_q.day;
    assign o_hour     = time_q.hour;
    assign o_minutes  = time_q.min;
    assign o_seconds  = time_q.sec;
    assign o_tick     = tick_q;
    assign o_valid    = valid_q;
    assign o_holdover = holdover_q;

endmodule

// File: tb/tb_tod_keeper.sv
// Bench for tod_keeper: directed calendar corners, randomized dates against a
// seconds-of-day reference, and PPS loss / holdover / realign timing.
module tb_tod_keeper;

    localparam int CPS  = 100;
    localparam int WIN  = 5;
    localparam int HMAX = 3;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_pps = 1'b0;
    logic        i_load_dv = 1'b0;
    logic [7:0]  i_year_h = '0, i_year_l = '0, i_month = '0, i_day = '0;
    logic [7:0]  i_hour = '0, i_minutes = '0, i_seconds = '0;
    logic [15:0] o_year;
    logic [7:0]  o_month, o_day, o_hour, o_minutes, o_seconds;
    logic        o_tick, o_valid, o_holdover;

    tod_keeper #(.CLKS_PER_SEC(CPS), .PPS_WINDOW(WIN), .HOLDOVER_MAX(HMAX)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_pps(i_pps), .i_load_dv(i_load_dv),
        .i_year_h(i_year_h), .i_year_l(i_year_l), .i_month(i_month), .i_day(i_day),
        .i_hour(i_hour), .i_minutes(i_minutes), .i_seconds(i_seconds),
        .o_year(o_year), .o_month(o_month), .o_day(o_day), .o_hour(o_hour),
        .o_minutes(o_minutes), .o_seconds(o_seconds),
        .o_tick(o_tick), .o_valid(o_valid), .o_holdover(o_holdover)
    );

    always #5 i_clk = ~i_clk;

    wire [55:0] dut_t = {o_year, o_month, o_day, o_hour, o_minutes, o_seconds};

    int n_chk = 0, n_pass = 0;
    int cyc = 0, tick_cnt = 0, last_tick = -1;

    // Edge counter and tick log, sampled just after each rising edge.
    always @(posedge i_clk) begin
        #2;
        cyc = cyc + 1;
        if (o_tick) begin
            tick_cnt  = tick_cnt + 1;
            last_tick = cyc;
        end
    end

    task automatic chk(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    endtask

    function automatic logic [55:0] mk(int y, int mo, int d, int h, int mi, int s);
        return {16'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
    endfunction

    function automatic bit ref_leap(int y);
        return (y % 4 == 0) && (y != 2100) && (y != 2200) && (y != 2300);
    endfunction

    function automatic int ref_dim(int y, int mo);
        int len[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        return (mo == 2 && ref_leap(y)) ? 29 : len[mo-1];
    endfunction

    // Reference for valid fields: step seconds-of-day, then carry into the calendar.
    function automatic logic [55:0] ref_next(int y, int mo, int d, int h, int mi, int s);
        int sod = h * 3600 + mi * 60 + s + 1;
        if (sod == 86400) begin
            sod = 0;
            d++;
            if (d > ref_dim(y, mo)) begin
                d = 1;
                mo++;
                if (mo > 12) begin
                    mo = 1;
                    y++;
                end
            end
        end
        return mk(y, mo, d, sod / 3600, (sod / 60) % 60, sod % 60);
    endfunction

    task automatic drive_fields(input logic [55:0] t);
        {i_year_h, i_year_l, i_month, i_day, i_hour, i_minutes, i_seconds} = t;
    endtask

    task automatic do_load(input logic [55:0] t);
        drive_fields(t);
        i_load_dv = 1'b1;
        @(negedge i_clk);
        i_load_dv = 1'b0;
    endtask

    // Returns at the negedge where the PPS-driven tick is visible.
    task automatic pps_pulse();
        i_pps = 1'b1;
        repeat (4) @(negedge i_clk);
        i_pps = 1'b0;
    endtask

    task automatic wait_tick(input string tag, input int budget, output int t);
        int c0 = tick_cnt;
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge i_clk);
            if (tick_cnt != c0) begin
                t = last_tick;
                break;
            end
        end
        if (t < 0) begin
            chk({tag, "_timeout"}, 0, 1);
            t = cyc;
        end
    endtask

    task automatic load_pps(input string tag, input logic [55:0] ld, input logic [55:0] exp);
        int c0;
        do_load(ld);
        chk({tag, "_ld"}, dut_t, ld);
        chk({tag, "_vld"}, o_valid, 1);
        @(negedge i_clk);
        c0 = tick_cnt;
        pps_pulse();
        chk({tag, "_tick"}, o_tick, 1);
        chk({tag, "_time"}, dut_t, exp);
        chk({tag, "_hold"}, o_holdover, 0);
        repeat (2) @(negedge i_clk);
        chk({tag, "_once"}, tick_cnt - c0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, t0, t1, t2, t3, r;
        int y, mo, d, h, mi, s, idx;
        int yrs[7] = '{2000, 2023, 2024, 2100, 2200, 2300, 2400};

        // Reset state
        repeat (3) @(negedge i_clk);
        chk("rst_time", dut_t, 0);
        chk("rst_tick", o_tick, 0);
        chk("rst_vld", o_valid, 0);
        chk("rst_hold", o_holdover, 0);
        i_rst = 1'b0;

        // PPS while unset: no tick, nothing changes
        c0 = tick_cnt;
        pps_pulse();
        repeat (6) @(negedge i_clk);
        chk("unset_notick", tick_cnt - c0, 0);
        chk("unset_time", dut_t, 0);
        chk("unset_vld", o_valid, 0);
        do_load(mk(2025, 6, 30, 12, 0, 0));
        chk("first_vld", o_valid, 1);
        chk("first_time", dut_t, mk(2025, 6, 30, 12, 0, 0));

        // Calendar corners
        load_pps("leapfeb", mk(2024, 2, 28, 23, 59, 59), mk(2024, 2, 29, 0, 0, 0));
        load_pps("newyear", mk(2023, 12, 31, 23, 59, 59), mk(2024, 1, 1, 0, 0, 0));
        load_pps("y2100", mk(2100, 2, 28, 23, 59, 59), mk(2100, 3, 1, 0, 0, 0));
        load_pps("y2000", mk(2000, 2, 28, 23, 59, 59), mk(2000, 2, 29, 0, 0, 0));
        load_pps("leapsec", mk(2016, 12, 31, 23, 59, 60), mk(2017, 1, 1, 0, 0, 0));
        load_pps("badday", mk(2024, 4, 31, 23, 59, 59), mk(2024, 5, 1, 0, 0, 0));

        // Load landing in the same cycle as the PPS edge
        c0 = tick_cnt;
        drive_fields(mk(2024, 7, 4, 12, 34, 56));
        i_pps = 1'b1;
        repeat (3) @(negedge i_clk);
        i_load_dv = 1'b1;
        @(negedge i_clk);
        i_load_dv = 1'b0;
        i_pps = 1'b0;
        chk("ldtick_tick", o_tick, 1);
        chk("ldtick_time", dut_t, mk(2024, 7, 4, 12, 34, 57));
        repeat (2) @(negedge i_clk);
        chk("ldtick_once", tick_cnt - c0, 1);

        // Randomized dates, biased toward rollover boundaries
        for (int i = 0; i < 24; i++) begin
            idx = $urandom_range(0, 7);
            y   = (idx == 7) ? $urandom_range(1990, 2500) : yrs[idx];
            mo  = $urandom_range(1, 12);
            d   = $urandom_range(0, 1) ? ref_dim(y, mo) : $urandom_range(1, ref_dim(y, mo));
            h   = $urandom_range(0, 1) ? 23 : $urandom_range(0, 23);
            mi  = $urandom_range(0, 1) ? 59 : $urandom_range(0, 59);
            s   = $urandom_range(0, 1) ? 59 : $urandom_range(0, 59);
            load_pps($sformatf("rnd%0d", i), mk(y, mo, d, h, mi, s), ref_next(y, mo, d, h, mi, s));
        end

        // Regular PPS every CPS clocks
        for (int k = 0; k < 3; k++) begin
            pps_pulse();
            chk($sformatf("per%0d_tick", k), o_tick, 1);
            chk($sformatf("per%0d_hold", k), o_holdover, 0);
            if (k < 2) repeat (96) @(negedge i_clk);
        end
        t0 = last_tick;

        // PPS stops: holdover entry, then flywheel seconds
        wait_tick("syn1", 200, t1);
        chk("syn1_lat", t1 - t0, CPS + WIN);
        chk("syn1_hold", o_holdover, 1);
        chk("syn1_vld", o_valid, 1);
        wait_tick("syn2", 200, t2);
        chk("syn2_int", t2 - t1, CPS - WIN);
        chk("syn2_vld", o_valid, 1);
        wait_tick("syn3", 200, t3);
        chk("syn3_int", t3 - t2, CPS);
        chk("syn3_vld", o_valid, 0);
        chk("syn3_hold", o_holdover, 1);

        // Late PPS just after a synthetic tick: realign only
        c0 = tick_cnt;
        pps_pulse();
        chk("realign_notick", o_tick, 0);
        chk("realign_hold", o_holdover, 0);
        repeat (96) @(negedge i_clk);
        pps_pulse();
        chk("post_tick", o_tick, 1);
        chk("realign_once", tick_cnt - c0, 1);
        chk("realign_vld", o_valid, 0);
        t0 = last_tick;

        // Back into holdover, then reset with a competing load
        wait_tick("synb", 200, t1);
        chk("synb_lat", t1 - t0, CPS + WIN);
        chk("synb_hold", o_holdover, 1);
        drive_fields(mk(2030, 1, 1, 0, 0, 0));
        i_rst = 1'b1;
        i_load_dv = 1'b1;
        @(negedge i_clk);
        chk("mrst_time", dut_t, 0);
        chk("mrst_vld", o_valid, 0);
        chk("mrst_hold", o_holdover, 0);
        chk("mrst_tick", o_tick, 0);
        i_rst = 1'b0;
        i_load_dv = 1'b0;
        @(negedge i_clk);
        chk("mrst2_vld", o_valid, 0);
        chk("mrst2_time", dut_t, 0);
        c0 = tick_cnt;
        pps_pulse();
        repeat (4) @(negedge i_clk);
        chk("mrst_unset_notick", tick_cnt - c0, 0);
        load_pps("postrst", mk(2099, 12, 31, 23, 59, 59), mk(2100, 1, 1, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
